// File: rtl/apb_reg_arbiter_pkg.sv
// Shared definitions for the two-master APB register-file arbiter:
// FSM state encoding and default APB widths / timeout length.
package apb_reg_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SETUP_ENC  = 2'd1;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETUP  = ST_SETUP_ENC,
    ST_ACCESS = ST_ACCESS_ENC
  } arb_state_e;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin grant. last_grant_i is the index of the master served
// most recently; on a tie the other master wins. Purely combinational.
module apb_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  // One-hot grant selection
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/apb_reg_arbiter.sv
// Two-master APB arbiter in front of a single register-file slave.
// Round-robin grant, one transfer in flight, registered slave-side
// SETUP/ACCESS phases; the non-granted master is stalled with PREADY low.
// Optional macro APB_ARB_TIMEOUT_EN: forces an error completion when the
// slave holds PREADY low for TIMEOUT_CYC ACCESS cycles.
module apb_reg_arbiter
  import apb_reg_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL_M0,
  input  logic              PSEL_M1,
  input  logic              PENABLE_M0,
  input  logic              PENABLE_M1,
  input  logic              PWRITE_M0,
  input  logic              PWRITE_M1,
  input  logic [ADDR_W-1:0] PADDR_M0,
  input  logic [ADDR_W-1:0] PADDR_M1,
  input  logic [DATA_W-1:0] PWDATA_M0,
  input  logic [DATA_W-1:0] PWDATA_M1,
  output logic [DATA_W-1:0] PRDATA_M0,
  output logic [DATA_W-1:0] PRDATA_M1,
  output logic              PREADY_M0,
  output logic              PREADY_M1,
  output logic              PSLVERR_M0,
  output logic              PSLVERR_M1,
  output logic              PSEL_S,
  output logic              PENABLE_S,
  output logic              PWRITE_S,
  output logic [ADDR_W-1:0] PADDR_S,
  output logic [DATA_W-1:0] PWDATA_S,
  input  logic [DATA_W-1:0] PRDATA_S,
  input  logic              PREADY_S,
  input  logic              PSLVERR_S
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gidx_q, gidx_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic              in_access_s;
  logic              timeout_s;
  logic              complete_s;
  logic [1:0]        arb_req_s;
  logic              arb_last_s;
  logic [1:0]        gnt_s;
  logic              cap_write_s;
  logic [ADDR_W-1:0] cap_addr_s;
  logic [DATA_W-1:0] cap_data_s;

  // Master-side PENABLE is not needed: the grant keys on PSEL alone.
  logic unused_penable_s;
  assign unused_penable_s = PENABLE_M0 ^ PENABLE_M1;

  assign in_access_s = (state_q == ST_ACCESS);
  assign complete_s  = in_access_s && (PREADY_S || timeout_s);

  // In the completion cycle only the other master may be picked next;
  // the finishing master's PSEL is masked and it counts as last served.
  always_comb begin
    if (in_access_s) begin
      arb_req_s  = {PSEL_M1 & ~gidx_q, PSEL_M0 & gidx_q};
      arb_last_s = gidx_q;
    end else begin
      arb_req_s  = {PSEL_M1, PSEL_M0};
      arb_last_s = last_grant_q;
    end
  end

  apb_rr_arb2 u_arb (
    .req_i        (arb_req_s),
    .last_grant_i (arb_last_s),
    .gnt_o        (gnt_s)
  );

  // Request fields of the master that would be captured on a grant
  always_comb begin
    if (gnt_s[1]) begin
      cap_write_s = PWRITE_M1;
      cap_addr_s  = PADDR_M1;
      cap_data_s  = PWDATA_M1;
    end else begin
      cap_write_s = PWRITE_M0;
      cap_addr_s  = PADDR_M0;
      cap_data_s  = PWDATA_M0;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Fires on the TIMEOUT_CYC-th consecutive ACCESS cycle without PREADY_S
  assign timeout_s = in_access_s && !PREADY_S &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Timeout counter: cleared on SETUP entry, advances while ACCESS stalls
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_d == ST_SETUP) begin
      to_cnt_d = {TO_W{1'b0}};
    end else if (in_access_s && !PREADY_S) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Timeout counter register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      to_cnt_q <= {TO_W{1'b0}};
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  localparam logic [31:0] TIMEOUT_VEC = 32'(TIMEOUT_CYC);
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_VEC;
  assign timeout_s        = 1'b0;
`endif

  // Next-state, grant capture and registered slave-side phase control
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gidx_d       = gidx_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          gidx_d    = gnt_s[1];
          pwrite_d  = cap_write_s;
          paddr_d   = cap_addr_s;
          pwdata_d  = cap_data_s;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (complete_s) begin
          last_grant_d = gidx_q;
          if (gnt_s != 2'b00) begin
            gidx_d    = gnt_s[1];
            pwrite_d  = cap_write_s;
            paddr_d   = cap_addr_s;
            pwdata_d  = cap_data_s;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
          end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and slave-side output registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gidx_q       <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= {ADDR_W{1'b0}};
      pwdata_q     <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gidx_q       <= gidx_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

  assign PSEL_S    = psel_q;
  assign PENABLE_S = penable_q;
  assign PWRITE_S  = pwrite_q;
  assign PADDR_S   = paddr_q;
  assign PWDATA_S  = pwdata_q;

  // Response routing: only the granted master, only in the completion
  // cycle, and only if it is still selecting (a dropped PSEL discards it)
  always_comb begin
    PREADY_M0  = 1'b0;
    PREADY_M1  = 1'b0;
    PRDATA_M0  = {DATA_W{1'b0}};
    PRDATA_M1  = {DATA_W{1'b0}};
    PSLVERR_M0 = 1'b0;
    PSLVERR_M1 = 1'b0;
    if (complete_s) begin
      if (gidx_q && PSEL_M1) begin
        PREADY_M1  = 1'b1;
        PRDATA_M1  = timeout_s ? {DATA_W{1'b0}} : PRDATA_S;
        PSLVERR_M1 = timeout_s | PSLVERR_S;
      end else if (!gidx_q && PSEL_M0) begin
        PREADY_M0  = 1'b1;
        PRDATA_M0  = timeout_s ? {DATA_W{1'b0}} : PRDATA_S;
        PSLVERR_M0 = timeout_s | PSLVERR_S;
      end else begin
        PREADY_M0 = 1'b0;
        PREADY_M1 = 1'b0;
      end
    end else begin
      PREADY_M0 = 1'b0;
      PREADY_M1 = 1'b0;
    end
  end

endmodule
